// File: rtl/ni_req_flit_arbiter_pkg.sv
// Shared NoC request-path definitions: arbiter FSM states, grant-source
// encoding and the outstanding-counter width helper.
package ni_req_flit_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_PKT = 2'd1,
        RD_PKT = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_src_t;

    // Bits needed to hold 0..max_cnt inclusive.
    function automatic int outs_cnt_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/ni_req_flit_arbiter_if.sv
// Flit handshake bundle between the two packet builders, the arbiter and
// the out_buffer write/full port. The arbiter uses the slave modport.
interface ni_req_flit_arbiter_if #(
    parameter int FLIT_WIDTH = 80
);
    logic [FLIT_WIDTH-1:0] wr_flit;
    logic                  wr_valid;
    logic                  wr_last;
    logic                  wr_stall;
    logic [FLIT_WIDTH-1:0] rd_flit;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_stall;
    logic [FLIT_WIDTH-1:0] flit;
    logic                  valid;
    logic                  stall;

    modport master (
        output wr_flit, wr_valid, wr_last,
        output rd_flit, rd_valid, rd_last,
        output stall,
        input  wr_stall, rd_stall, flit, valid
    );

    modport slave (
        input  wr_flit, wr_valid, wr_last,
        input  rd_flit, rd_valid, rd_last,
        input  stall,
        output wr_stall, rd_stall, flit, valid
    );
endinterface

// File: rtl/ni_req_flit_arbiter_outs_counter.sv
// Saturating outstanding-transaction counter with a sticky underflow flag.
// A simultaneous increment and (valid) decrement cancel out.
module ni_outs_counter #(
    parameter int MAX_CNT = 16,
    parameter int CNT_WD  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [CNT_WD-1:0] count,
    output logic              underflow
);
    localparam logic [CNT_WD-1:0] SAT = CNT_WD'(MAX_CNT);

    logic dec_ok;
    assign dec_ok = dec && (count != '0);

    // Count update: cancel on inc+dec, saturate on inc, ignore dec at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (dec && (count == '0))
                underflow <= 1'b1;
            if (inc && !dec_ok) begin
                if (count != SAT)
                    count <= count + 1'b1;
            end else if (dec_ok && !inc) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/ni_req_flit_arbiter.sv
// Round-robin, packet-atomic arbiter sharing the NoC output flit port
// between the write (AW+W) and read (AR) packet builders, with
// per-direction outstanding counters.
// Optional feature: define NI_ARB_OUTS_LIMIT_EN to make a source whose
// counter is at MAX_OUTSTANDING ineligible for a new packet.
module ni_req_flit_arbiter
    import ni_req_flit_arbiter_pkg::*;
#(
    parameter  int FLIT_WIDTH      = 80,
    parameter  int MAX_OUTSTANDING = 16,
    localparam int CNT_WD          = outs_cnt_width(MAX_OUTSTANDING)
) (
    input  logic                  clk,
    input  logic                  rst,
    ni_req_flit_arbiter_if.slave  bus,
    input  logic                  decr_wr,
    input  logic                  decr_rd,
    output logic [CNT_WD-1:0]     outs_wr,
    output logic [CNT_WD-1:0]     outs_rd,
    output logic                  underflow_err
);
    arb_state_t            state, state_nxt;
    gnt_src_t              last_gnt;
    gnt_src_t              gnt_src;
    logic                  gnt_vld;
    logic                  elig_wr, elig_rd;
    logic                  sel_valid, sel_last;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  xfer;
    logic                  head_xfer;
    logic                  wr_uflow, rd_uflow;

`ifdef NI_ARB_OUTS_LIMIT_EN
    assign elig_wr = bus.wr_valid && (outs_wr != CNT_WD'(MAX_OUTSTANDING));
    assign elig_rd = bus.rd_valid && (outs_rd != CNT_WD'(MAX_OUTSTANDING));
`else
    assign elig_wr = bus.wr_valid;
    assign elig_rd = bus.rd_valid;
`endif

    // Grant selection, output mux, stall steering and next-state logic.
    // Grant is suppressed while reset is asserted so outputs go idle at once.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_src   = GNT_WR;
        state_nxt = state;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (elig_wr && elig_rd) begin
                        gnt_vld = 1'b1;
                        gnt_src = (last_gnt == GNT_RD) ? GNT_WR : GNT_RD;
                    end else if (elig_wr) begin
                        gnt_vld = 1'b1;
                        gnt_src = GNT_WR;
                    end else if (elig_rd) begin
                        gnt_vld = 1'b1;
                        gnt_src = GNT_RD;
                    end
                end
                WR_PKT: begin
                    gnt_vld = 1'b1;
                    gnt_src = GNT_WR;
                end
                RD_PKT: begin
                    gnt_vld = 1'b1;
                    gnt_src = GNT_RD;
                end
                default: ;
            endcase
        end

        sel_valid    = (gnt_src == GNT_WR) ? bus.wr_valid : bus.rd_valid;
        sel_last     = (gnt_src == GNT_WR) ? bus.wr_last  : bus.rd_last;
        sel_flit     = (gnt_src == GNT_WR) ? bus.wr_flit  : bus.rd_flit;
        bus.valid    = gnt_vld && sel_valid;
        bus.flit     = gnt_vld ? sel_flit : '0;
        bus.wr_stall = !(gnt_vld && (gnt_src == GNT_WR)) || bus.stall;
        bus.rd_stall = !(gnt_vld && (gnt_src == GNT_RD)) || bus.stall;
        xfer         = bus.valid && !bus.stall;
        head_xfer    = xfer && (state == IDLE);

        unique case (state)
            IDLE: begin
                if (xfer && !sel_last)
                    state_nxt = (gnt_src == GNT_WR) ? WR_PKT : RD_PKT;
            end
            WR_PKT, RD_PKT: begin
                if (xfer && sel_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and round-robin pointer; pointer moves on each head flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= GNT_RD;
        end else begin
            state <= state_nxt;
            if (head_xfer)
                last_gnt <= gnt_src;
        end
    end

    ni_outs_counter #(
        .MAX_CNT (MAX_OUTSTANDING),
        .CNT_WD  (CNT_WD)
    ) u_outs_wr (
        .clk       (clk),
        .rst       (rst),
        .inc       (head_xfer && (gnt_src == GNT_WR)),
        .dec       (decr_wr),
        .count     (outs_wr),
        .underflow (wr_uflow)
    );

    ni_outs_counter #(
        .MAX_CNT (MAX_OUTSTANDING),
        .CNT_WD  (CNT_WD)
    ) u_outs_rd (
        .clk       (clk),
        .rst       (rst),
        .inc       (head_xfer && (gnt_src == GNT_RD)),
        .dec       (decr_rd),
        .count     (outs_rd),
        .underflow (rd_uflow)
    );

    assign underflow_err = wr_uflow || rd_uflow;
endmodule

// File: doc/ni_req_flit_arbiter.md
# ni_req_flit_arbiter

Sequencer in the NI initiator request path. It shares the single NoC output flit port, which feeds the `out_buffer` write/full interface, between the write-packet builder (AW+W) and the read-packet builder (AR). Arbitration is round-robin with packet atomicity. The block also keeps per-direction outstanding-transaction counters and can throttle new packets when a counter is saturated.

## Interface
Parameters:
- `FLIT_WIDTH`, 80, flit width in bits.
- `MAX_OUTSTANDING`, 16, saturation limit per direction, 1..255.
- `CNT_WD`, `$clog2(MAX_OUTSTANDING+1)`, counter width; derived, not overridden.

Ports:
- `clk`, in, 1: NoC clock; all state on the rising edge.
- `rst`, in, 1: reset, asynchronous assert, active-low.
- `wr_flit`, in, FLIT_WIDTH: write-builder flit.
- `wr_valid`, in, 1: write flit present.
- `wr_last`, in, 1: write flit is the packet tail.
- `wr_stall`, out, 1: write flit not accepted this cycle.
- `rd_flit`, in, FLIT_WIDTH: read-builder flit.
- `rd_valid`, in, 1: read flit present.
- `rd_last`, in, 1: read flit is the packet tail.
- `rd_stall`, out, 1: read flit not accepted this cycle.
- `flit`, out, FLIT_WIDTH: flit to `out_buffer` `data_in`.
- `valid`, out, 1: flit to `out_buffer` `write`.
- `stall`, in, 1: `out_buffer` `full`.
- `decr_wr`, in, 1: one write response retired (single-cycle pulse).
- `decr_rd`, in, 1: one read response retired (single-cycle pulse).
- `outs_wr`, out, CNT_WD: outstanding write packets.
- `outs_rd`, out, CNT_WD: outstanding read packets.
- `underflow_err`, out, 1: sticky; set when a decrement arrives while its counter is 0.

## Operation
- Transfer rule: a flit moves when `valid && !stall`. A source holds its flit and `last` stable while its stall output is high. Sources must not retract `valid` mid-packet.
- FSM states:
  - IDLE: no packet locked.
  - WR_PKT: write packet locked.
  - RD_PKT: read packet locked.
- IDLE behaviour:
  - Eligible sources are those with `valid` high and, when the limit is enabled, counter < MAX_OUTSTANDING.
  - One eligible source: it is granted.
  - Both eligible: the source opposite the round-robin pointer `last_gnt` is granted.
  - The grant is combinational, so the head flit can pass in the same cycle.
- Head flit transferred:
  - `last_gnt` is updated to the granted source.
  - The matching counter increments.
  - If the head is not tail, the FSM goes to WR_PKT or RD_PKT. A head+tail packet stays in IDLE.
- WR_PKT / RD_PKT:
  - Only the locked source is muxed to the output; the other source's stall is forced to 1.
  - Return to IDLE on transfer of a flit with `last` set.
  - Eligibility is not re-evaluated inside a packet.
- Stall outputs: the granted source sees `stall` pass through; the non-granted source sees 1. In IDLE with no grant, both are 1.
- `valid` output = granted source's `valid`. `flit` = granted source's flit, or 0 when nothing is granted.
- Counters:
  - Increment and decrement in the same cycle leaves the counter unchanged.
  - A decrement at 0 is ignored and sets `underflow_err`.
  - An increment never exceeds MAX_OUTSTANDING, because the limit blocks it. With the limit disabled, the counter saturates at MAX_OUTSTANDING.

## Timing
- Reset values:
  - FSM = IDLE, `last_gnt` = read, so the first tie goes to write.
  - Counters = 0, `underflow_err` = 0.
  - `valid` = 0, `flit` = 0, `wr_stall` = `rd_stall` = 1.
- Datapath latency 0 cycles (combinational mux). The only registered state is FSM, pointer, counters and error flag.
- Counter outputs update the cycle after the transfer or pulse edge.
- A reset mid-packet drops the lock immediately; the partial packet is the sources' responsibility.
- `stall` high for N cycles holds the grant and the FSM unchanged for N cycles.

## Configuration
- `NI_ARB_OUTS_LIMIT_EN` defined: a source whose counter equals MAX_OUTSTANDING is ineligible in IDLE.
- Not defined: eligibility depends on `valid` only. Counters and `underflow_err` remain functional for observation.

## Structure
- The shared NoC package holds:
  - the FSM state enum (IDLE, WR_PKT, RD_PKT);
  - the grant-source encoding (GNT_WR, GNT_RD);
  - the counter-width helper.
- The two identical counters live in the sub-module `ni_outs_counter` (inc, dec, sat limit, count, underflow).

## Test plan
- Write packet of 1+4 flits and read head+tail flit asserted together after reset, `stall` 0: write flits 0..4 on cycles 0..4, read on cycle 5; `outs_wr` = 1, `outs_rd` = 1.
- Continuous requests from both sources, all packets single-flit: grants alternate W,R,W,R; no source is granted twice in a row.
- `stall` high for 3 cycles mid write packet while `rd_valid` is high: write flit held, `rd_stall` = 1 throughout, no read flit interleaved.
- With `NI_ARB_OUTS_LIMIT_EN` and MAX_OUTSTANDING = 2: issue 3 reads; the third is held (`rd_stall` = 1) until a `decr_rd` pulse, then passes; `outs_rd` shows 2, 1, 2.
- Simultaneous read head transfer and `decr_rd`: `outs_rd` unchanged. `decr_wr` at 0: `outs_wr` stays 0 and `underflow_err` = 1 until reset.
- `rst` asserted mid write packet: outputs reach their reset values asynchronously; after release, a tie grants write first.
